// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: EX-stage operand forwarding selects and load-use stall generator
module fwd_sel_ctrl #(
  parameter int RegAW   = 5,
  parameter bit ZeroReg = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RegAW-1:0] id_rs1,
  input  logic [RegAW-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RegAW-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             pipe_stall,
  input  logic             pipe_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             load_use_stall
);
  logic             r_ex_v, r_ex_we, r_ex_ld, r_mem_v, r_mem_we, r_mem_ld, r_wb_v, r_wb_we;
  logic [RegAW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic [1:0]       r_a_sel, r_b_sel;
  logic             w_ex1, w_mem1, w_wb1, w_ex2, w_mem2, w_wb2;
  logic             w_haz1, w_haz2, w_bubble;
  logic [1:0]       w_a_sel, w_b_sel;

  function automatic logic hit(input logic v, input logic we, input logic [RegAW-1:0] rd,
                               input logic [RegAW-1:0] r);
    return v & we & (rd == r) & !(ZeroReg & (r == '0));
  endfunction

  assign w_ex1  = hit(r_ex_v, r_ex_we, r_ex_rd, id_rs1);
  assign w_mem1 = hit(r_mem_v, r_mem_we, r_mem_rd, id_rs1);
  assign w_wb1  = hit(r_wb_v, r_wb_we, r_wb_rd, id_rs1);
  assign w_ex2  = hit(r_ex_v, r_ex_we, r_ex_rd, id_rs2);
  assign w_mem2 = hit(r_mem_v, r_mem_we, r_mem_rd, id_rs2);
  assign w_wb2  = hit(r_wb_v, r_wb_we, r_wb_rd, id_rs2);

  // a load still in EX cannot forward yet; the consumer must wait one cycle
  assign w_haz1 = id_rs1_used & w_ex1 & r_ex_ld;
  assign w_haz2 = id_rs2_used & w_ex2 & r_ex_ld;

  // a flushed instruction is dead, so it never raises a stall
  assign load_use_stall = id_valid & (w_haz1 | w_haz2) & !pipe_flush;
  assign w_bubble       = pipe_flush | load_use_stall;

  // nearest writer wins; unused or invalid sources read the register file
  always_comb begin
    w_a_sel = !(id_valid & id_rs1_used) ? 2'b00 : w_ex1 ? 2'b01 : w_mem1 ? 2'b10 : w_wb1 ? 2'b11 : 2'b00;
    w_b_sel = !(id_valid & id_rs2_used) ? 2'b00 : w_ex2 ? 2'b01 : w_mem2 ? 2'b10 : w_wb2 ? 2'b11 : 2'b00;
  end

  // advance the writer tracker and register selects; flush overrides an external freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_ex_v, r_ex_we, r_ex_ld, r_mem_v, r_mem_we, r_mem_ld, r_wb_v, r_wb_we} <= '0;
      r_ex_rd  <= '0;
      r_mem_rd <= '0;
      r_wb_rd  <= '0;
      r_a_sel  <= 2'b00;
      r_b_sel  <= 2'b00;
    end else if (pipe_flush || !pipe_stall) begin
      r_wb_v   <= r_mem_v;
      r_wb_we  <= r_mem_we;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_we <= r_ex_we;
      r_mem_ld <= r_ex_ld;
      r_mem_rd <= r_ex_rd;
      r_ex_v   <= id_valid & !w_bubble;
      r_ex_we  <= id_we;
      r_ex_ld  <= id_is_load;
      r_ex_rd  <= id_rd;
      r_a_sel  <= w_bubble ? 2'b00 : w_a_sel;
      r_b_sel  <= w_bubble ? 2'b00 : w_b_sel;
    end
  end

  assign fwd_a_sel = r_a_sel;
  assign fwd_b_sel = r_b_sel;
endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb_fwd_sel_ctrl: directed vectors for forwarding selects and load-use stall
module tb_fwd_sel_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       pipe_stall = 1'b0, pipe_flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       load_use_stall;
  int         n_vec = 0, n_err = 0;

  fwd_sel_ctrl #(.RegAW(5), .ZeroReg(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_is_load = ld;
  endtask

  task automatic idle;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick;
  endtask

  initial begin
    #12;
    chk("rst_a", fwd_a_sel, 2'b00);
    chk("rst_b", fwd_b_sel, 2'b00);
    chk("rst_stall", {1'b0, load_use_stall}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tick;
    // 1: add x3 then add x4,x3,x3
    drv(1, 1, 1, 2, 1, 3, 1, 0); tick;
    drv(1, 3, 1, 3, 1, 4, 1, 0); #1;
    chk("t1_stall", {1'b0, load_use_stall}, 2'b00);
    tick;
    chk("t1_a", fwd_a_sel, 2'b01);
    chk("t1_b", fwd_b_sel, 2'b01);
    idle;
    // 2: WB-hold, out-of-window, x0
    drv(1, 0, 0, 0, 0, 5, 1, 0); tick;
    drv(1, 1, 1, 2, 1, 10, 1, 0); tick;
    drv(1, 1, 1, 2, 1, 11, 1, 0); tick;
    drv(1, 5, 1, 5, 1, 12, 1, 0); tick;
    chk("t2_wb_a", fwd_a_sel, 2'b11);
    chk("t2_wb_b", fwd_b_sel, 2'b11);
    idle;
    drv(1, 0, 0, 0, 0, 5, 1, 0); tick;
    drv(1, 1, 1, 2, 1, 10, 1, 0); tick;
    drv(1, 1, 1, 2, 1, 11, 1, 0); tick;
    drv(1, 1, 1, 2, 1, 12, 1, 0); tick;
    drv(1, 5, 1, 5, 1, 13, 1, 0); tick;
    chk("t2_far_a", fwd_a_sel, 2'b00);
    chk("t2_far_b", fwd_b_sel, 2'b00);
    idle;
    drv(1, 0, 0, 0, 0, 0, 1, 0); tick;
    drv(1, 0, 1, 0, 1, 14, 1, 0); tick;
    chk("t2_x0_a", fwd_a_sel, 2'b00);
    chk("t2_x0_b", fwd_b_sel, 2'b00);
    idle;
    // 3: load-use
    drv(1, 1, 1, 0, 0, 7, 1, 1); tick;
    drv(1, 7, 1, 1, 1, 8, 1, 0); #1;
    chk("t3_stall", {1'b0, load_use_stall}, 2'b01);
    tick; #1;
    chk("t3_stall_gone", {1'b0, load_use_stall}, 2'b00);
    chk("t3_bub_a", fwd_a_sel, 2'b00);
    tick;
    chk("t3_a", fwd_a_sel, 2'b10);
    chk("t3_b", fwd_b_sel, 2'b00);
    idle;
    // 4: nearest writer, freeze
    drv(1, 0, 0, 0, 0, 9, 1, 0); tick;
    drv(1, 0, 0, 0, 0, 9, 1, 0); tick;
    drv(1, 9, 1, 0, 0, 15, 0, 0); tick;
    chk("t4_r3_a", fwd_a_sel, 2'b01);
    drv(1, 0, 0, 9, 1, 16, 0, 0);
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_hold_a", fwd_a_sel, 2'b01);
      chk("t4_hold_b", fwd_b_sel, 2'b00);
    end
    pipe_stall = 1'b0;
    tick;
    chk("t4_a", fwd_a_sel, 2'b00);
    chk("t4_b", fwd_b_sel, 2'b10);
    idle;
    // 5: flush beats load-use
    drv(1, 0, 0, 0, 0, 7, 1, 1); tick;
    drv(1, 7, 1, 1, 1, 8, 1, 0);
    pipe_flush = 1'b1; #1;
    chk("t5_no_stall", {1'b0, load_use_stall}, 2'b00);
    tick;
    pipe_flush = 1'b0;
    chk("t5_a", fwd_a_sel, 2'b00);
    chk("t5_b", fwd_b_sel, 2'b00);
    drv(1, 8, 1, 7, 1, 17, 0, 0); #1;
    chk("t5_stall2", {1'b0, load_use_stall}, 2'b00);
    tick;
    chk("t5_dead_a", fwd_a_sel, 2'b00);
    chk("t5_mem_b", fwd_b_sel, 2'b10);
    idle;
    // 6: async reset mid-stream
    drv(1, 0, 0, 0, 0, 3, 1, 0); tick;
    drv(1, 1, 1, 0, 0, 18, 0, 0); tick;
    drv(1, 3, 1, 0, 0, 7, 1, 1); tick;
    chk("t6_pre_a", fwd_a_sel, 2'b10);
    drv(1, 7, 1, 0, 0, 8, 1, 0); #1;
    chk("t6_pre_stall", {1'b0, load_use_stall}, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_a", fwd_a_sel, 2'b00);
    chk("t6_rst_stall", {1'b0, load_use_stall}, 2'b00);
    #2 rst = 1'b0;
    drv(1, 7, 1, 3, 1, 19, 0, 0);
    tick;
    chk("t6_post_a", fwd_a_sel, 2'b00);
    chk("t6_post_b", fwd_b_sel, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
